// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO read and write pointer controllers.
// Functions work on a fixed maximum width; callers zero-extend narrower pointers
// and slice the result back, which is exact for Gray/binary conversion because
// zero upper bits do not change the prefix-XOR.
package fifo_ptr_pkg;

  localparam int unsigned PTR_MAX_W = 32;
  localparam int unsigned POP_W     = 6;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;
  typedef logic [POP_W-1:0]     pop_t;

  // Binary to reflected Gray code.
  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = '0;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Number of set bits; applied to (new_gray ^ old_gray) it gives the Hamming distance of a hop.
  function automatic pop_t gray_popcount(input ptr_word_t diff);
    pop_t cnt;
    cnt = '0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      cnt = cnt + pop_t'(diff[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_sync_nff.sv
// Multi-flop synchronizer for a Gray-coded bus crossing into this clock domain.
// STAGES must be at least 2. All stages clear to zero on the asynchronous reset.
module gray_sync_nff #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the asynchronous input through the flop chain, one stage per edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int s = 1; s < STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ptr_sync.sv
// Read-side pointer controller of the async FIFO. Synchronizes the write Gray
// pointer, owns the read pointer (binary and Gray), and produces the registered
// empty flag, occupancy count and a sticky Gray-integrity error.
//
// Read handshake: a read fires on an i_clk edge where i_rd_en=1 and o_empty=0
// (o_empty is the inverse of "ready"). i_rd_en while o_empty=1 is dropped with no
// side effect; i_rd_en need not be held and there is no back-pressure beyond o_empty.
module fifo_rd_ptr_sync
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH:0]   i_wr_ptr_gray,
  input  logic                  i_rd_en,
  output logic [ADDR_WIDTH:0]   o_rd_ptr_bin,
  output logic [ADDR_WIDTH-1:0] ow_rd_addr,
  output logic [ADDR_WIDTH:0]   o_rd_ptr_gray,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_gray_err
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PW-1:0] w_wr_gray_s;
  logic [PW-1:0] w_wr_bin_s;

  logic [PW-1:0] rd_bin_q,  rd_bin_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic          empty_q,   empty_d;
  logic [PW-1:0] count_q,   count_d;
  logic          err_q,     err_d;
  logic [PW-1:0] wr_gray_prev_q;

  logic          w_fire;
  logic          w_hop_err;
  logic          w_cnt_err;

  gray_sync_nff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .d_i   (i_wr_ptr_gray),
    .q_o   (w_wr_gray_s)
  );

  assign w_wr_bin_s = PW'(gray2bin(ptr_word_t'(w_wr_gray_s)));

  // Next read pointer, flags and count, all derived from the post-read pointer so
  // the draining read raises empty on the same edge that moves the pointer.
  always_comb begin
    w_fire    = i_rd_en & ~empty_q;
    rd_bin_d  = rd_bin_q + PW'(w_fire);
    rd_gray_d = PW'(bin2gray(ptr_word_t'(rd_bin_d)));
    empty_d   = (rd_gray_d == w_wr_gray_s);
    count_d   = w_wr_bin_s - rd_bin_d;
    // A legal synchronized Gray pointer moves by at most one bit per read-clock edge.
    w_hop_err = gray_popcount(ptr_word_t'(w_wr_gray_s ^ wr_gray_prev_q)) > pop_t'(1);
    w_cnt_err = (count_d > DEPTH_C);
    err_d     = err_q | w_hop_err | w_cnt_err;
  end

  // Pointer, flag and count registers; reset leaves the FIFO empty with no error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_bin_q       <= '0;
      rd_gray_q      <= '0;
      empty_q        <= 1'b1;
      count_q        <= '0;
      err_q          <= 1'b0;
      wr_gray_prev_q <= '0;
    end else begin
      rd_bin_q       <= rd_bin_d;
      rd_gray_q      <= rd_gray_d;
      empty_q        <= empty_d;
      count_q        <= count_d;
      err_q          <= err_d;
      wr_gray_prev_q <= w_wr_gray_s;
    end
  end

  assign o_rd_ptr_bin  = rd_bin_q;
  assign ow_rd_addr    = rd_bin_q[ADDR_WIDTH-1:0];
  assign o_rd_ptr_gray = rd_gray_q;
  assign o_empty       = empty_q;
  assign o_count       = count_q;
  assign o_gray_err    = err_q;

endmodule

// File: tb/tb_fifo_rd_ptr_sync.sv
// Bench for fifo_rd_ptr_sync with ADDR_WIDTH=3, SYNC_STAGES=2 (4-bit pointers).
module tb_fifo_rd_ptr_sync;

  localparam int AW    = 3;
  localparam int SS    = 2;
  localparam int PW    = AW + 1;
  localparam int NPTR  = 1 << PW;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset / DUT ----------------
  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic [PW-1:0] wr_gray = '0;
  logic          rd_en   = 1'b0;

  logic [PW-1:0] rd_bin;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_gray;
  logic          empty;
  logic [PW-1:0] count;
  logic          gray_err;

  always #5 clk = ~clk;

  fifo_rd_ptr_sync #(
    .ADDR_WIDTH  (AW),
    .SYNC_STAGES (SS)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_ptr_gray (wr_gray),
    .i_rd_en       (rd_en),
    .o_rd_ptr_bin  (rd_bin),
    .ow_rd_addr    (rd_addr),
    .o_rd_ptr_gray (rd_gray),
    .o_empty       (empty),
    .o_count       (count),
    .o_gray_err    (gray_err)
  );

  // ---------------- counters and check ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Gray decode by searching for the binary value whose Gray image matches.
  function automatic int g2b(input logic [PW-1:0] g);
    for (int v = 0; v < NPTR; v++) begin
      if (PW'(v ^ (v >> 1)) == g) return v;
    end
    return 0;
  endfunction

  function automatic int b2g(input int v);
    return (v ^ (v >> 1)) % NPTR;
  endfunction

  function automatic int popc(input logic [PW-1:0] x);
    int c;
    c = 0;
    for (int i = 0; i < PW; i++) c += int'(x[i]);
    return c;
  endfunction

  // Delay line: m_dly[SS-1] is the write pointer the read side currently sees.
  logic [PW-1:0] m_dly [SS];
  int            m_rd    = 0;
  int            m_count = 0;
  logic          m_empty = 1'b1;
  logic          m_err   = 1'b0;
  logic [PW-1:0] m_prev  = '0;

  function automatic int nxt_rd();
    return (m_rd + ((rd_en && !m_empty) ? 1 : 0)) % NPTR;
  endfunction

  function automatic int nxt_cnt();
    return (g2b(m_dly[SS-1]) - nxt_rd() + NPTR) % NPTR;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SS; i++) m_dly[i] <= '0;
      m_rd    <= 0;
      m_count <= 0;
      m_empty <= 1'b1;
      m_err   <= 1'b0;
      m_prev  <= '0;
    end else begin
      m_rd    <= nxt_rd();
      m_count <= nxt_cnt();
      m_empty <= (nxt_cnt() == 0);
      m_err   <= m_err | (popc(m_dly[SS-1] ^ m_prev) > 1) | (nxt_cnt() > DEPTH);
      m_prev  <= m_dly[SS-1];
      m_dly[0] <= wr_gray;
      for (int i = 1; i < SS; i++) m_dly[i] <= m_dly[i-1];
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_ptr_bin",  rd_bin,   m_rd);
      chk("rd_ptr_gray", rd_gray,  b2g(m_rd));
      chk("rd_addr",     rd_addr,  m_rd % DEPTH);
      chk("empty",       empty,    m_empty);
      chk("count",       count,    m_count);
      chk("gray_err",    gray_err, m_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_wr_bin(input int v);
    wr_gray = PW'(b2g(v));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst     = 1'b1;
    wr_gray = '0;
    rd_en   = 1'b0;
    #1;
    chk("rst_empty",    empty,    1);
    chk("rst_count",    count,    0);
    chk("rst_rd_bin",   rd_bin,   0);
    chk("rst_rd_gray",  rd_gray,  0);
    chk("rst_gray_err", gray_err, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic single_entry();
    wr_gray = 4'b0001;
    tick(2);
    chk("se_empty_early", empty, 1);
    tick(1);
    chk("se_empty", empty, 0);
    chk("se_count", count, 1);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk("se_rd_bin",  rd_bin,  1);
    chk("se_rd_gray", rd_gray, 4'b0001);
    chk("se_empty2",  empty,   1);
    chk("se_count2",  count,   0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    #1 rst = 1'b1;
    apply_reset();

    // Single entry in, single entry out.
    single_entry();

    // Fill to DEPTH, drain fully, then an extra read while empty.
    apply_reset();
    for (int v = 1; v <= 8; v++) begin
      set_wr_bin(v);
      tick(1);
    end
    tick(2);
    chk("fill_wr_gray_in", wr_gray, 4'b1100);
    chk("fill_count", count, 8);
    chk("fill_empty", empty, 0);
    chk("fill_err",   gray_err, 0);
    rd_en = 1'b1;
    tick(8);
    chk("drain_rd_bin",  rd_bin,  8);
    chk("drain_rd_gray", rd_gray, 4'b1100);
    chk("drain_empty",   empty,   1);
    chk("drain_count",   count,   0);
    tick(1);
    chk("extra_rd_bin",  rd_bin,  8);
    chk("extra_err",     gray_err, 0);
    rd_en = 1'b0;

    // Wrap: write side to 14, read to 14, write past 15 to 2, read past 15.
    for (int v = 9; v <= 14; v++) begin
      set_wr_bin(v);
      tick(1);
    end
    tick(2);
    rd_en = 1'b1;
    tick(6);
    rd_en = 1'b0;
    chk("wrap_rd14", rd_bin, 14);
    chk("wrap_empty14", empty, 1);
    for (int v = 15; v <= 18; v++) begin
      set_wr_bin(v % NPTR);
      tick(1);
    end
    tick(2);
    chk("wrap_count4", count, 4);
    chk("wrap_rd_hold", rd_bin, 14);
    rd_en = 1'b1;
    tick(1);
    chk("wrap_rd15",      rd_bin,  15);
    chk("wrap_gray15",    rd_gray, 4'b1000);
    tick(1);
    chk("wrap_rd0",       rd_bin,  0);
    chk("wrap_gray0",     rd_gray, 4'b0000);
    chk("wrap_count2",    count,   2);
    tick(2);
    rd_en = 1'b0;
    chk("wrap_rd2",       rd_bin,  2);
    chk("wrap_empty_end", empty,   1);
    chk("wrap_err",       gray_err, 0);

    // Read fired while the write pointer is still arriving.
    set_wr_bin(3);
    tick(3);
    rd_en = 1'b1;
    set_wr_bin(4);
    tick(1);
    rd_en = 1'b0;
    tick(2);
    chk("sim_rd3",    rd_bin, 3);
    chk("sim_count1", count,  1);

    // Two-bit Gray hop sets the sticky error.
    apply_reset();
    wr_gray = 4'b0011;
    tick(2);
    chk("hop_err_early", gray_err, 0);
    tick(1);
    chk("hop_err", gray_err, 1);
    wr_gray = 4'b0010;
    tick(1);
    wr_gray = 4'b0000;
    tick(4);
    chk("hop_err_sticky", gray_err, 1);
    chk("hop_count0",     count,    0);

    // Legal single-bit steps beyond DEPTH: count 9 is reported unsaturated and flags an error.
    apply_reset();
    for (int v = 1; v <= 9; v++) begin
      set_wr_bin(v);
      tick(1);
    end
    tick(2);
    chk("over_count9", count,    9);
    chk("over_err",    gray_err, 1);

    // Async reset mid-stream, then a clean single-entry recovery.
    apply_reset();
    for (int v = 1; v <= 5; v++) begin
      set_wr_bin(v);
      tick(1);
    end
    tick(2);
    chk("mid_count5", count, 5);
    chk("mid_empty0", empty, 0);
    apply_reset();
    single_entry();
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
